// File: rtl/telemetry_pkg.sv
// telemetry_pkg: shared FSM state, packet lengths and byte indices.
// TELEMETRY_CHECKSUM_EN selects the 7-byte packet with an XOR checksum.
package telemetry_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int PKT_LEN_BASE = 6;
  localparam int PKT_LEN_CSUM = 7;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam logic [2:0] IDX_SYNC    = 3'd0;
  localparam logic [2:0] IDX_MODE    = 3'd1;
  localparam logic [2:0] IDX_LIVES   = 3'd2;
  localparam logic [2:0] IDX_SCORE_H = 3'd3;
  localparam logic [2:0] IDX_SCORE_M = 3'd4;
  localparam logic [2:0] IDX_SCORE_L = 3'd5;
  localparam logic [2:0] IDX_CSUM    = 3'd6;

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serialiser for one byte with its own baud counter.
// ready is high in IDLE and in the last stop-bit cycle, so bytes chain gap-free.
module uart_tx_byte
  import telemetry_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       stop_pre,
  output logic       tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE = BW'(CLKS_PER_BIT - 2);

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          wrap;

  assign wrap     = baud == BAUD_MAX;
  assign ready    = (state == IDLE) || ((state == STOP) && wrap);
  assign stop_pre = (state == STOP) && (baud == BAUD_PRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid) begin
            shreg <= data;
            tx    <= 1'b0;
            baud  <= '0;
            state <= START;
          end
        end
        START: begin
          if (wrap) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (wrap) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (wrap) begin
            baud <= '0;
            if (valid) begin
              shreg <= data;
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/telemetry_uart_tx.sv
// telemetry_uart_tx: snapshots game state and sends it as a UART packet.
// Define TELEMETRY_CHECKSUM_EN to append the XOR checksum byte.
module telemetry_uart_tx
  import telemetry_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 104,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  scene,
  input  logic [4:0]  level,
  input  logic [1:0]  lives,
  input  logic [19:0] score,
  output logic        tx,
  output logic        busy,
  output logic        done
);

`ifdef TELEMETRY_CHECKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'(PKT_LEN_CSUM - 1);
`else
  localparam logic [2:0] LAST_BYTE = 3'(PKT_LEN_BASE - 1);
`endif

  logic [1:0]  s_scene;
  logic [4:0]  s_level;
  logic [1:0]  s_lives;
  logic [19:0] s_score;
  logic        pending;
  logic [2:0]  byte_idx;
  logic [2:0]  next_idx;
  logic [7:0]  byte_data;
  logic        last, accept, advance;
  logic        valid, ready, stop_pre;

  assign last     = byte_idx == LAST_BYTE;
  assign accept   = !busy && start;
  assign advance  = busy && ready;
  assign valid    = accept || advance;
  assign next_idx = (busy && !last) ? byte_idx + 3'd1 : IDX_SYNC;

`ifdef TELEMETRY_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = {1'b0, s_scene, s_level} ^ {6'b0, s_lives}
              ^ {4'b0, s_score[19:16]} ^ s_score[15:8] ^ s_score[7:0];
`endif

  always_comb begin
    byte_data = SYNC_BYTE;
    unique case (next_idx)
      IDX_MODE:    byte_data = {1'b0, s_scene, s_level};
      IDX_LIVES:   byte_data = {6'b0, s_lives};
      IDX_SCORE_H: byte_data = {4'b0, s_score[19:16]};
      IDX_SCORE_M: byte_data = s_score[15:8];
      IDX_SCORE_L: byte_data = s_score[7:0];
`ifdef TELEMETRY_CHECKSUM_EN
      IDX_CSUM:    byte_data = csum;
`endif
      default:     byte_data = SYNC_BYTE;
    endcase
  end

  // done/busy are decided one cycle early so they land on the final stop cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      pending  <= 1'b0;
      byte_idx <= '0;
      s_scene  <= '0;
      s_level  <= '0;
      s_lives  <= '0;
      s_score  <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        busy     <= 1'b1;
        pending  <= 1'b0;
        byte_idx <= '0;
        s_scene  <= scene;
        s_level  <= level;
        s_lives  <= lives;
        s_score  <= score;
      end else if (busy) begin
        if (start) pending <= 1'b1;
        if (stop_pre && last) begin
          done <= 1'b1;
          if (!(pending || start)) busy <= 1'b0;
        end
        if (ready) begin
          if (!last) begin
            byte_idx <= byte_idx + 3'd1;
          end else begin
            byte_idx <= '0;
            pending  <= 1'b0;
            s_scene  <= scene;
            s_level  <= level;
            s_lives  <= lives;
            s_score  <= score;
          end
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (valid),
    .data    (byte_data),
    .ready   (ready),
    .stop_pre(stop_pre),
    .tx      (tx)
  );

endmodule

// File: tb/tb_telemetry_uart_tx.sv
// tb_telemetry_uart_tx: directed stimulus, UART-decoding monitor, byte scoreboard.
// Packet length follows TELEMETRY_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_telemetry_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
`ifdef TELEMETRY_CHECKSUM_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif

  localparam logic [7:0] PKT_A [7] = '{8'hA5, 8'h23, 8'h02, 8'h01, 8'h23, 8'h45, 8'h46};
  localparam logic [7:0] PKT_F [7] = '{8'hA5, 8'h23, 8'h02, 8'h0F, 8'hFF, 8'hFF, 8'h2E};

  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic [1:0]  scene = 0;
  logic [4:0]  level = 0;
  logic [1:0]  lives = 0;
  logic [19:0] score = 0;
  logic        tx, busy, done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] exp_q [$];

  telemetry_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .scene(scene),
    .level(level),
    .lives(lives),
    .score(score),
    .tx   (tx),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit f, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(f ? PKT_F[i] : PKT_A[i]);
  endtask

  task automatic wait_done(input int lim, output int t, output logic b);
    t = -1;
    b = 1'bx;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        t = cyc;
        b = busy;
        break;
      end
    end
    if (t < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got none expected done within %0d cycles", lim);
    end
  endtask

  // UART receiver: samples mid-bit, drops frames cut by reset
  logic [7:0] rx_b;
  logic       rx_ok, rx_stop;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        rx_ok = 1'b1;
        repeat (CPB / 2) begin @(negedge clk); if (!rst_n) rx_ok = 1'b0; end
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) begin @(negedge clk); if (!rst_n) rx_ok = 1'b0; end
          rx_b[i] = tx;
        end
        repeat (CPB) begin @(negedge clk); if (!rst_n) rx_ok = 1'b0; end
        rx_stop = tx;
        if (rx_ok) begin
          check("stop_bit", {31'b0, rx_stop}, 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got %02h expected no byte", rx_b);
          end else begin
            check("rx_byte", {24'b0, rx_b}, {24'b0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  int   t0, t1, t2, run_len, run_at, stop_len, bad_runs, bad_idle;
  logic prev, b_at, got_done;

  task automatic idle_window(input int n);
    bad_idle = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad_idle++;
    end
  endtask

  initial begin
    // reset and idle
    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 1);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    rst_n = 1;
    idle_window(200);
    check("idle_200", bad_idle, 0);

    // single packet, snapshot isolation, bit timing
    scene = 2'd1; level = 5'd3; lives = 2'd2; score = 20'h1_2345;
    t0 = cyc; start = 1; push(0, NB);
    @(negedge clk); start = 0;
    check("lat_tx", {31'b0, tx}, 0);
    check("lat_busy", {31'b0, busy}, 1);
    prev = tx; run_len = 1; run_at = 0;
    stop_len = -1; bad_runs = 0; got_done = 0; t1 = -1; b_at = 1'bx;
    for (int k = 0; k < 400 && !got_done; k++) begin
      @(negedge clk);
      if (cyc == t0 + 2) score = 20'h0;
      if (done === 1'b1) begin got_done = 1; t1 = cyc; b_at = busy; end
      if (tx !== prev) begin
        if (run_len % CPB != 0) bad_runs++;
        if (run_at == FRAME + 9 * CPB) stop_len = run_len;
        prev = tx; run_len = 1; run_at = cyc - (t0 + 1);
      end else begin
        run_len++;
      end
    end
    check("done_cycle", t1, t0 + NB * FRAME);
    check("busy_at_done", {31'b0, b_at}, 0);
    check("run_multiple", bad_runs, 0);
    check("stop_len", stop_len, CPB);
    @(negedge clk);
    check("done_pulse", {31'b0, done}, 0);
    repeat (40) @(negedge clk);
    check("q_empty_single", exp_q.size(), 0);

    // back-to-back: three starts while busy give exactly one extra packet
    score = 20'h1_2345;
    t0 = cyc; start = 1; push(0, NB);
    @(negedge clk); start = 0;
    repeat (48) @(negedge clk);
    score = 20'hF_FFFF; start = 1; push(1, NB);
    @(negedge clk); start = 0;
    repeat (50) @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (50) @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    wait_done(400, t1, b_at);
    check("b2b_done1", t1, t0 + NB * FRAME);
    check("b2b_busy_held", {31'b0, b_at}, 1);
    @(negedge clk);
    check("b2b_no_gap", {31'b0, tx}, 0);
    wait_done(400, t2, b_at);
    check("b2b_done2", t2, t1 + NB * FRAME);
    check("b2b_busy_drop", {31'b0, b_at}, 0);
    idle_window(100);
    check("b2b_single_extra", bad_idle, 0);
    check("q_empty_b2b", exp_q.size(), 0);

    // start in the same cycle as done
    t0 = cyc; start = 1; push(1, NB);
    @(negedge clk); start = 0;
    wait_done(400, t1, b_at);
    start = 1; push(1, NB);
    @(negedge clk); start = 0;
    check("sd_tx", {31'b0, tx}, 0);
    check("sd_busy", {31'b0, busy}, 1);
    wait_done(400, t2, b_at);
    check("sd_done2", t2, t1 + NB * FRAME);
    repeat (40) @(negedge clk);
    check("q_empty_sd", exp_q.size(), 0);

    // reset during data bits of B2
    score = 20'h1_2345;
    t0 = cyc; start = 1; push(0, 2);
    @(negedge clk); start = 0;
    while (cyc < t0 + 1 + 2 * FRAME + 12) @(negedge clk);
    check("pre_rst_tx", {31'b0, tx}, 0);
    rst_n = 0;
    #1;
    check("async_tx", {31'b0, tx}, 1);
    check("async_busy", {31'b0, busy}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    idle_window(100);
    check("post_rst_idle", bad_idle, 0);
    check("q_empty_rst", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
